// File: rtl/gol_pkg.sv
// gol_pkg: shared sizes and types for the 3x3 Game of Life front end.
// Imported by the loader and by anything that talks to the grid.
package gol_pkg;

  localparam int GOL_ROWS = 3;
  localparam int GOL_COLS = 3;

  typedef enum logic [1:0] {
    LOAD,
    INIT,
    RUN,
    REPORT
  } gol_loader_state_t;

  typedef logic [GOL_ROWS-1:0][GOL_COLS-1:0] gol_board_t;

endpackage

// File: rtl/gol_loader.sv
// gol_loader: serial seed writer, initialise strobe and snapshot capture
// for the Game of Life grid.
module gol_loader
  import gol_pkg::*;
#(
  parameter int ROWS  = GOL_ROWS,
  parameter int COLS  = GOL_COLS,
  parameter int GENS  = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  input  logic [ROWS-1:0][COLS-1:0]  board_in,
  output logic [ROWS-1:0][COLS-1:0]  grid_in,
  output logic                       initialise,
  output logic [ROWS-1:0][COLS-1:0]  snap,
  output logic                       snap_valid,
  input  logic                       snap_ready,
  output logic                       busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);
  localparam logic [CNT_W-1:0] GEN_LAST = CNT_W'(GENS);

  if (GENS < 0 || GENS >= (1 << CNT_W)) begin : g_bad_gens
    $error("gol_loader: GENS must lie in [0, 2**CNT_W)");
  end

  gol_loader_state_t r_state;
  gol_loader_state_t w_next;

  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [CNT_W-1:0] r_gen;
  logic             r_snap_valid;

  logic w_take;
  logic w_last_bit;
  logic w_gen_done;

  assign w_take     = bit_ready && bit_valid;
  assign w_last_bit = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_gen_done = (r_gen == GEN_LAST);
  assign busy       = (r_state != LOAD);
  assign snap_valid = r_snap_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    bit_ready  = 1'b0;
    initialise = 1'b0;
    unique case (r_state)
      LOAD: begin
        bit_ready = 1'b1;
        if (bit_valid && w_last_bit) begin
          w_next = INIT;
        end
      end
      INIT: begin
        initialise = 1'b1;
        w_next     = RUN;
      end
      RUN: begin
        if (w_gen_done) begin
          w_next = REPORT;
        end
      end
      REPORT: begin
        if (r_snap_valid && snap_ready) begin
          w_next = LOAD;
        end
      end
    endcase
  end

  // Row/column pair walks the board row-major, one cell per transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
      grid_in <= '0;
    end else if (w_take) begin
      grid_in[r_row][r_col] <= bit_in;
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // r_gen tracks which generation board_in currently shows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gen        <= '0;
      snap         <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      if (r_state == INIT) begin
        r_gen <= '0;
      end
      if (r_state == RUN) begin
        if (w_gen_done) begin
          snap         <= board_in;
          r_snap_valid <= 1'b1;
        end else begin
          r_gen <= r_gen + 1'b1;
        end
      end
      if (r_state == REPORT && snap_ready) begin
        r_snap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gol_loader.sv
// tb_gol_loader: three loaders (GENS 0, 1, 4), each beside a behavioural grid,
// checked every cycle against a timeline model built from the protocol rules.
module tb_gol_loader;
  import gol_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset      [NI];
  logic       bit_in     [NI];
  logic       bit_valid  [NI];
  logic       bit_ready  [NI];
  logic       initialise [NI];
  logic       snap_valid [NI];
  logic       snap_ready [NI];
  logic       busy       [NI];
  gol_board_t board      [NI];
  gol_board_t grid_in    [NI];
  gol_board_t snap       [NI];

  bit         exp_ready [NI];
  bit         exp_init  [NI];
  bit         exp_busy  [NI];
  bit         exp_valid [NI];
  gol_board_t exp_grid  [NI];
  gol_board_t exp_snap  [NI];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int gens_of(int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    gol_loader #(
      .ROWS (3),
      .COLS (3),
      .GENS ((g == 0) ? 0 : ((g == 1) ? 1 : 4)),
      .CNT_W(8)
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .bit_in    (bit_in[g]),
      .bit_valid (bit_valid[g]),
      .bit_ready (bit_ready[g]),
      .board_in  (board[g]),
      .grid_in   (grid_in[g]),
      .initialise(initialise[g]),
      .snap      (snap[g]),
      .snap_valid(snap_valid[g]),
      .snap_ready(snap_ready[g]),
      .busy      (busy[g])
    );
  end

  // Conway rules on a 3x3 board with dead cells beyond the edge.
  function automatic gol_board_t life(gol_board_t b);
    gol_board_t n;
    int cnt;
    n = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 3 &&
                c + dc >= 0 && c + dc < 3) begin
              cnt += int'(b[r+dr][c+dc]);
            end
          end
        end
        n[r][c] = (cnt == 3) || (b[r][c] && cnt == 2);
      end
    end
    return n;
  endfunction

  function automatic gol_board_t evolve(gol_board_t b, int g);
    gol_board_t x;
    x = b;
    for (int k = 0; k < g; k++) x = life(x);
    return x;
  endfunction

  // Behavioural grid: loads on initialise, otherwise advances every edge.
  initial for (int i = 0; i < NI; i++) board[i] = '0;
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      board[i] <= initialise[i] ? grid_in[i] : life(board[i]);
    end
  end

  task automatic chk(input string nm, input int i,
                     input logic [8:0] got, input logic [8:0] want);
    n_total++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, i, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset[i]) chk("bit_ready", i, 9'(bit_ready[i]), 9'(exp_ready[i]));
      chk("initialise", i, 9'(initialise[i]), 9'(exp_init[i]));
      chk("busy", i, 9'(busy[i]), 9'(exp_busy[i]));
      chk("snap_valid", i, 9'(snap_valid[i]), 9'(exp_valid[i]));
      chk("grid_in", i, grid_in[i], exp_grid[i]);
      chk("snap", i, snap[i], exp_snap[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_reset(input int i);
    exp_ready[i] = 1'b1;
    exp_init[i]  = 1'b0;
    exp_busy[i]  = 1'b0;
    exp_valid[i] = 1'b0;
    exp_grid[i]  = '0;
    exp_snap[i]  = '0;
  endtask

  task automatic do_reset(input int i);
    reset[i] = 1'b1;
    bit_valid[i] = 1'b0;
    exp_reset(i);
    step();
    step();
    reset[i] = 1'b0;
    step();
  endtask

  // Sends the first nbits of pat, with random idle gaps between transfers.
  task automatic load(input int i, input gol_board_t pat, input int nbits,
                      input int max_gap);
    logic b;
    for (int k = 0; k < nbits; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        bit_valid[i]  = 1'b0;
        bit_in[i]     = 1'($urandom);
        snap_ready[i] = 1'($urandom);
        step();
      end
      b = pat[k/3][k%3];
      bit_valid[i]  = 1'b1;
      bit_in[i]     = b;
      snap_ready[i] = 1'($urandom);
      step();
      exp_grid[i][k/3][k%3] = b;
      if (k == 8) begin
        exp_ready[i] = 1'b0;
        exp_init[i]  = 1'b1;
        exp_busy[i]  = 1'b1;
      end
    end
    bit_valid[i]  = 1'b0;
    snap_ready[i] = 1'b0;
  endtask

  task automatic noise(input int i);
    bit_valid[i]  = 1'($urandom);
    bit_in[i]     = 1'($urandom);
    snap_ready[i] = 1'($urandom);
  endtask

  // Entered in the INIT cycle; returns in LOAD after the snap handshake.
  task automatic run_report(input int i, input int hold);
    noise(i);
    step();
    exp_init[i] = 1'b0;
    repeat (gens_of(i) + 1) begin
      noise(i);
      step();
    end
    exp_valid[i] = 1'b1;
    exp_snap[i]  = evolve(exp_grid[i], gens_of(i));
    repeat (hold) begin
      bit_valid[i]  = 1'($urandom);
      bit_in[i]     = 1'($urandom);
      snap_ready[i] = 1'b0;
      step();
    end
    snap_ready[i] = 1'b1;
    bit_valid[i]  = 1'b0;
    step();
    exp_valid[i] = 1'b0;
    exp_busy[i]  = 1'b0;
    exp_ready[i] = 1'b1;
    snap_ready[i] = 1'b0;
  endtask

  task automatic full_run(input int i, input gol_board_t pat, input int hold);
    load(i, pat, 9, 2);
    run_report(i, hold);
  endtask

  localparam gol_board_t BLINK_V = 9'b010_010_010;
  localparam gol_board_t BLINK_H = 9'b000_111_000;
  localparam gol_board_t BLOCK   = 9'b000_011_011;
  localparam gol_board_t SINGLE  = 9'b000_010_000;

  gol_board_t pat;

  initial begin
    for (int i = 0; i < NI; i++) begin
      reset[i]      = 1'b1;
      bit_in[i]     = 1'b0;
      bit_valid[i]  = 1'b0;
      snap_ready[i] = 1'b0;
      exp_reset(i);
    end
    step();
    step();
    for (int i = 0; i < NI; i++) reset[i] = 1'b0;
    step();

    // Partial load discarded by reset, then a fresh pattern.
    pat = 9'b101_101_011;
    load(2, pat, 5, 1);
    repeat (4) step();
    do_reset(2);
    pat = 9'b100_010_101;
    load(2, pat, 9, 0);
    chk("fresh_grid_in", 2, grid_in[2], 9'b100_010_101);
    run_report(2, 1);

    full_run(1, BLINK_V, 2);
    chk("blinker_g1", 1, snap[1], BLINK_H);
    full_run(2, BLINK_V, 0);
    chk("blinker_g4", 2, snap[2], BLINK_V);
    full_run(2, BLOCK, 10);
    chk("block_g4", 2, snap[2], BLOCK);
    full_run(1, SINGLE, 1);
    chk("single_g1", 1, snap[1], 9'b000_000_000);
    full_run(0, BLINK_V, 3);
    chk("blinker_g0", 0, snap[0], BLINK_V);

    // Reset while running: loader returns to LOAD, grid keeps evolving.
    load(1, BLOCK, 9, 0);
    noise(1);
    step();
    exp_init[1] = 1'b0;
    do_reset(1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI; i++) begin
        pat = 9'($urandom);
        full_run(i, pat, $urandom_range(0, 4));
        if (i == 0) chk("seed_g0", 0, snap[0], pat);
      end
    end

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gol_loader.md
Name: gol_loader

Overview:
- Front-end writer for the 3x3 Game of Life grid.
- Accepts a seed pattern serially over a valid/ready bit stream and assembles it into the grid's parallel `in` array.
- Pulses `initialise` for one cycle, lets the grid run a fixed number of generations, then captures the grid's `out` board and presents it with a valid/ready handshake.
- Sits between the test/host interface and the gol grid; it is the grid's only source of `in` and `initialise`.

Parameters:
- ROWS, 3, grid rows.
- COLS, 3, grid columns.
- GENS, 4, generations to run after load before capture; 0 is legal and captures the seed.
- CNT_W, 8, width of the generation counter; GENS must be < 2**CNT_W.

Ports:
- clk  input  1  clock shared with the grid.
- reset  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial seed bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  loader accepts a bit this cycle.
- board_in  input  [ROWS-1:0][COLS-1:0]  live grid state, wired from the grid's `out`.
- grid_in  output  [ROWS-1:0][COLS-1:0]  seed pattern, wired to the grid's `in`.
- initialise  output  1  one-cycle load strobe to the grid.
- snap  output  [ROWS-1:0][COLS-1:0]  captured board after GENS generations.
- snap_valid  output  1  snap holds a valid result.
- snap_ready  input  1  consumer accepts snap.
- busy  output  1  high in INIT, RUN and REPORT.

Behaviour:
- Reset (asynchronous, active-high, any state):
  - state=LOAD, bit index k=0, gen_cnt=0.
  - grid_in=0, snap=0, initialise=0, snap_valid=0, busy=0, bit_ready=1 once reset deasserts.
- A bit transfer occurs on a clk edge with bit_valid & bit_ready.
- Bit mapping is row-major, first bit first: transfer number k writes grid_in[k/COLS][k%COLS].
- States:
  - LOAD:
    - bit_ready=1.
    - Each transfer writes grid_in and increments k.
    - A transfer with k==ROWS*COLS-1 sets k=0 and moves to INIT.
    - bit_valid low: hold, no change.
  - INIT:
    - Exactly one cycle; initialise=1, bit_ready=0.
    - The grid loads grid_in on this edge.
    - Next state RUN with gen_cnt=0.
  - RUN:
    - initialise=0.
    - gen_cnt counts grid edges since load, so board_in equals generation gen_cnt.
    - If gen_cnt==GENS: snap<=board_in, snap_valid<=1, go to REPORT.
    - Else gen_cnt<=gen_cnt+1.
    - Latency from the INIT cycle to snap_valid is GENS+2 clk edges.
  - REPORT:
    - snap and snap_valid are held stable; the grid keeps evolving but snap does not change.
    - On snap_valid & snap_ready: snap_valid<=0, go to LOAD.
    - snap keeps its last value after the handshake.
- grid_in changes only on LOAD transfers; it is not cleared between runs. Each load overwrites all ROWS*COLS bits.
- initialise is never high outside INIT, and never high for two consecutive cycles.
- Simultaneous events:
  - bit_valid in INIT, RUN or REPORT is ignored (bit_ready=0, no transfer).
  - snap_ready with snap_valid low has no effect.
- Partial load: holding bit_valid low mid-pattern keeps k and the grid_in contents indefinitely.
- Reset mid-load discards the partial pattern.
- Reset mid-run returns to LOAD; the grid itself is not reset by this block.
- gen_cnt saturates behaviour is unneeded because GENS < 2**CNT_W is a legal-parameter check. Elaborate with $error if violated.

Decomposition:
- Package gol_pkg holds:
  - localparams GOL_ROWS=3, GOL_COLS=3;
  - typedef enum logic [1:0] {LOAD, INIT, RUN, REPORT} gol_loader_state_t;
  - typedef logic [GOL_ROWS-1:0][GOL_COLS-1:0] gol_board_t.
- No sub-module; the FSM, index counter and generation counter are small enough for one module.
- The top-level bench instantiates gol_loader and the gol grid side by side.

Test Plan:
- Reset during LOAD after 5 bits, then load 9 bits of a fresh pattern → grid_in equals only the fresh pattern; initialise pulses once, exactly one cycle after the 9th transfer.
- Blinker, GENS=1: bits 0,1,0,0,1,0,0,1,0 (vertical, column 1) → snap=[1][0],[1][1],[1][2] set, i.e. rows 000/111/000; snap_valid high exactly 3 edges after the INIT cycle.
- Blinker, GENS=4 → snap equals the vertical seed 010/010/010.
- Block: bits 1,1,0,1,1,0,0,0,0, GENS=4 → snap=110/110/000, stable.
- Single cell at [1][1], GENS=1 → snap=000/000/000.
- Backpressure: hold snap_ready low for 10 cycles in REPORT → snap is constant and bit_ready=0 throughout. Raise snap_ready → snap_valid falls next edge and bit_ready=1.
- GENS=0 → snap equals the seed.
- bit_valid toggling during RUN → no effect on grid_in.
